// File: rtl/tone_pkg.sv
// Shared definitions for the DDS tone oscillator: waveform mode encoding
// and the full-scale helper used when shaping samples.
package tone_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } tone_mode_e;

    // Largest positive magnitude used for a signed sample of the given width.
    function automatic longint full_scale(input int width);
        return (longint'(1) << (width - 1)) - longint'(1);
    endfunction

endpackage

// File: rtl/tone_shaper.sv
// Combinational phase-to-waveform mapping; receives the top OUT_W+1 phase
// bits and produces the unscaled signed sample for the selected mode.
module tone_shaper
    import tone_pkg::*;
#(
    parameter int OUT_W = 24
) (
    input  logic [OUT_W:0]          phase_top,
    input  tone_mode_e              mode,
    input  logic [7:0]              duty,
    output logic signed [OUT_W-1:0] w
);

    localparam logic signed [OUT_W-1:0] FS      = OUT_W'(full_scale(OUT_W));
    localparam logic        [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0] saw_raw;
    logic [OUT_W-1:0] tri_u;
    logic [OUT_W-1:0] tri_raw;

    // The most negative code is clamped so every waveform stays symmetric about zero.
    always_comb begin
        saw_raw = {~phase_top[OUT_W], phase_top[OUT_W-1:1]};
        tri_u   = phase_top[OUT_W] ? ~phase_top[OUT_W-1:0] : phase_top[OUT_W-1:0];
        tri_raw = {~tri_u[OUT_W-1], tri_u[OUT_W-2:0]};
        w       = '0;
        case (mode)
            MODE_SQUARE: w = (phase_top[OUT_W -: 8] < duty) ? FS : -FS;
            MODE_SAW:    w = (saw_raw == MIN_NEG) ? -FS : $signed(saw_raw);
            MODE_TRI:    w = (tri_raw == MIN_NEG) ? -FS : $signed(tri_raw);
            default:     w = '0;
        endcase
    end

endmodule

// File: rtl/tone_osc.sv
// Phase-accumulator tone oscillator with a shadowed configuration that is
// only applied at a phase wrap (or immediately while stopped).
module tone_osc
    import tone_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 24,
    parameter int AMP_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     cfg_wr,
    input  logic [PHASE_W-1:0]       cfg_inc,
    input  logic [1:0]               cfg_mode,
    input  logic [7:0]               cfg_duty,
    input  logic [AMP_W-1:0]         cfg_amp,
    output logic                     cfg_pending,
    output logic                     wrap,
    output logic signed [OUT_W-1:0]  tone,
    output logic                     tone_valid
);

    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [PHASE_W-1:0]       inc_act_q, inc_act_d, inc_pend_q, inc_pend_d;
    tone_mode_e               mode_act_q, mode_act_d, mode_pend_q, mode_pend_d;
    logic [7:0]               duty_act_q, duty_act_d, duty_pend_q, duty_pend_d;
    logic [AMP_W-1:0]         amp_act_q, amp_act_d, amp_pend_q, amp_pend_d;
    logic                     pending_q, pending_d;
    logic                     wrap_q, wrap_d;
    logic signed [OUT_W-1:0]  w_q, w_d;
    logic [AMP_W-1:0]         amp_s1_q, amp_s1_d;
    logic                     valid_s1_q, valid_s1_d;
    logic signed [OUT_W-1:0]  tone_q, tone_d;
    logic                     tone_valid_q, tone_valid_d;

    logic [PHASE_W:0]          add_full;
    logic                      apply_edge;
    logic signed [OUT_W+AMP_W:0] product;
    logic                      prod_unused_hi;
    logic [AMP_W-1:0]          prod_unused_lo;
    logic signed [OUT_W-1:0]   scaled;

    tone_shaper #(.OUT_W(OUT_W)) u_shaper (
        .phase_top (phase_q[PHASE_W-1 -: OUT_W+1]),
        .mode      (mode_act_q),
        .duty      (duty_act_q),
        .w         (w_d)
    );

    // A write on an applying edge bypasses the shadow so the newest values win.
    always_comb begin
        add_full    = {1'b0, phase_q} + {1'b0, inc_act_q};
        apply_edge  = !en || add_full[PHASE_W];
        phase_d     = en ? add_full[PHASE_W-1:0] : phase_q;
        wrap_d      = en && add_full[PHASE_W];
        inc_act_d   = inc_act_q;
        mode_act_d  = mode_act_q;
        duty_act_d  = duty_act_q;
        amp_act_d   = amp_act_q;
        inc_pend_d  = inc_pend_q;
        mode_pend_d = mode_pend_q;
        duty_pend_d = duty_pend_q;
        amp_pend_d  = amp_pend_q;
        pending_d   = pending_q;
        if (cfg_wr && apply_edge) begin
            inc_act_d  = cfg_inc;
            mode_act_d = tone_mode_e'(cfg_mode);
            duty_act_d = cfg_duty;
            amp_act_d  = cfg_amp;
            pending_d  = 1'b0;
        end else if (cfg_wr) begin
            inc_pend_d  = cfg_inc;
            mode_pend_d = tone_mode_e'(cfg_mode);
            duty_pend_d = cfg_duty;
            amp_pend_d  = cfg_amp;
            pending_d   = 1'b1;
        end else if (apply_edge && pending_q) begin
            inc_act_d  = inc_pend_q;
            mode_act_d = mode_pend_q;
            duty_act_d = duty_pend_q;
            amp_act_d  = amp_pend_q;
            pending_d  = 1'b0;
        end
    end

    // Amplitude travels with its sample so a retune never mixes old shape and new gain.
    always_comb begin
        amp_s1_d     = amp_act_q;
        valid_s1_d   = en;
        product      = w_q * $signed({1'b0, amp_s1_q});
        {prod_unused_hi, scaled, prod_unused_lo} = product;
        tone_d       = valid_s1_q ? scaled : '0;
        tone_valid_d = valid_s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            inc_act_q    <= '0;
            mode_act_q   <= MODE_OFF;
            duty_act_q   <= '0;
            amp_act_q    <= '0;
            inc_pend_q   <= '0;
            mode_pend_q  <= MODE_OFF;
            duty_pend_q  <= '0;
            amp_pend_q   <= '0;
            pending_q    <= 1'b0;
            wrap_q       <= 1'b0;
            w_q          <= '0;
            amp_s1_q     <= '0;
            valid_s1_q   <= 1'b0;
            tone_q       <= '0;
            tone_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            inc_act_q    <= inc_act_d;
            mode_act_q   <= mode_act_d;
            duty_act_q   <= duty_act_d;
            amp_act_q    <= amp_act_d;
            inc_pend_q   <= inc_pend_d;
            mode_pend_q  <= mode_pend_d;
            duty_pend_q  <= duty_pend_d;
            amp_pend_q   <= amp_pend_d;
            pending_q    <= pending_d;
            wrap_q       <= wrap_d;
            w_q          <= w_d;
            amp_s1_q     <= amp_s1_d;
            valid_s1_q   <= valid_s1_d;
            tone_q       <= tone_d;
            tone_valid_q <= tone_valid_d;
        end
    end

    assign cfg_pending = pending_q;
    assign wrap        = wrap_q;
    assign tone        = tone_q;
    assign tone_valid  = tone_valid_q;

endmodule

// File: tb/tb_tone_osc.sv
// Self-checking bench for tone_osc: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of the oscillator.
module tb_tone_osc;

    localparam int     PHASE_W = 32;
    localparam int     OUT_W   = 24;
    localparam int     AMP_W   = 16;
    localparam longint FS      = 64'sd8388607;
    localparam longint HALF    = 64'sd8388608;
    localparam longint TWO24   = 64'sd16777216;
    localparam longint TWO31   = 64'sd2147483648;
    localparam longint TWO32   = 64'sd4294967296;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    en = 1'b0;
    logic                    cfg_wr = 1'b0;
    logic [PHASE_W-1:0]      cfg_inc = '0;
    logic [1:0]              cfg_mode = '0;
    logic [7:0]              cfg_duty = '0;
    logic [AMP_W-1:0]        cfg_amp = '0;
    logic                    cfg_pending;
    logic                    wrap;
    logic signed [OUT_W-1:0] tone;
    logic                    tone_valid;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    tone_osc #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .AMP_W(AMP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_wr      (cfg_wr),
        .cfg_inc     (cfg_inc),
        .cfg_mode    (cfg_mode),
        .cfg_duty    (cfg_duty),
        .cfg_amp     (cfg_amp),
        .cfg_pending (cfg_pending),
        .wrap        (wrap),
        .tone        (tone),
        .tone_valid  (tone_valid)
    );

    always #5 clk = ~clk;

    // Reference model state: active and pending configuration plus sample queue.
    typedef struct {
        longint tone;
        bit     valid;
    } sample_t;

    longint  m_phase = 0, m_inc = 0, m_amp = 0, p_inc = 0, p_amp = 0;
    int      m_mode = 0, m_duty = 0, p_mode = 0, p_duty = 0;
    bit      m_pend = 0, m_wrap = 0;
    longint  exp_tone = 0;
    bit      exp_valid = 0;
    sample_t pipe[$];

    function automatic longint waveOf(longint ph, int mode, int duty);
        longint v;
        longint t;
        v = 0;
        case (mode)
            1: v = ((ph >> 24) < longint'(duty)) ? FS : -FS;
            2: v = (ph >> 8) - HALF;
            3: begin
                t = (ph >> 7) % TWO24;
                if (ph >= TWO31) t = TWO24 - 1 - t;
                v = t - HALF;
            end
            default: v = 0;
        endcase
        if (v < -FS) v = -FS;
        return v;
    endfunction

    function automatic longint scaleOf(longint w, longint amp);
        return (w * amp) >>> AMP_W;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        sample_t s;
        sample_t cur;
        longint  sum;
        bit      carry;
        bit      apply;
        if (!rst_n) begin
            m_phase = 0; m_inc = 0; m_amp = 0; m_mode = 0; m_duty = 0;
            p_inc = 0; p_amp = 0; p_mode = 0; p_duty = 0;
            m_pend = 0; m_wrap = 0; exp_tone = 0; exp_valid = 0;
            pipe.delete();
            s.tone = 0; s.valid = 0;
            pipe.push_back(s);
        end else begin
            s.valid = en;
            s.tone  = en ? scaleOf(waveOf(m_phase, m_mode, m_duty), m_amp) : 0;
            pipe.push_back(s);
            cur       = pipe.pop_front();
            exp_tone  = cur.tone;
            exp_valid = cur.valid;
            sum    = m_phase + m_inc;
            carry  = en && (sum >= TWO32);
            m_wrap = carry;
            apply  = !en || carry;
            if (cfg_wr && apply) begin
                m_inc = longint'(cfg_inc); m_mode = int'(cfg_mode);
                m_duty = int'(cfg_duty); m_amp = longint'(cfg_amp);
                m_pend = 0;
            end else if (cfg_wr) begin
                p_inc = longint'(cfg_inc); p_mode = int'(cfg_mode);
                p_duty = int'(cfg_duty); p_amp = longint'(cfg_amp);
                m_pend = 1;
            end else if (apply && m_pend) begin
                m_inc = p_inc; m_mode = p_mode; m_duty = p_duty; m_amp = p_amp;
                m_pend = 0;
            end
            if (en) m_phase = sum % TWO32;
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("tone", longint'(tone), exp_tone);
            checkOutput("tone_valid", longint'(tone_valid), longint'(exp_valid));
            checkOutput("wrap", longint'(wrap), longint'(m_wrap));
            checkOutput("cfg_pending", longint'(cfg_pending), longint'(m_pend));
        end
    end

    task automatic applyStimulus(input bit e, input bit wr, input longint inc,
                                 input int mode, input int duty, input longint amp);
        en       = e;
        cfg_wr   = wr;
        cfg_inc  = 32'(inc);
        cfg_mode = 2'(mode);
        cfg_duty = 8'(duty);
        cfg_amp  = 16'(amp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cfg_wr = 1'b0;
        end
    endtask

    task automatic waitWrap(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!wrap && n < 64);
        checkOutput("wrap_seen", longint'(wrap), 1);
    endtask

    task automatic waitPhase(input longint target);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (m_phase != target && n < 64);
        if (m_phase != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL phase_wait actual=%0h expected=%0h", m_phase, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int     n;
        int     cnt_hi;
        int     cnt_lo;
        int     bad;
        longint s[16];

        #3 rst_n = 1'b0;
        step(2);
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        step(1);
        checkOutput("reset_tone", longint'(tone), 0);
        checkOutput("reset_valid", longint'(tone_valid), 0);

        // Square wave, 50% duty, full amplitude.
        applyStimulus(0, 1, 64'h1000_0000, 1, 128, 64'hFFFF);
        step(1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitWrap(n);
        waitWrap(n);
        checkOutput("sq_period", n, 16);
        step(2);
        checkOutput("sq_first", longint'(tone), 8388479);
        cnt_hi = 0;
        cnt_lo = 0;
        for (int i = 0; i < 16; i++) begin
            if (tone == 24'sd8388479) cnt_hi++;
            if (tone == -24'sd8388480) cnt_lo++;
            step(1);
        end
        checkOutput("sq_high_count", cnt_hi, 8);
        checkOutput("sq_low_count", cnt_lo, 8);

        // Retune while running: old period must complete first.
        waitPhase(64'h3000_0000);
        applyStimulus(1, 1, 64'h2000_0000, 1, 128, 64'hFFFF);
        step(1);
        checkOutput("retune_pending", longint'(cfg_pending), 1);
        waitWrap(n);
        checkOutput("retune_rest", n, 12);
        checkOutput("retune_applied", longint'(cfg_pending), 0);
        waitWrap(n);
        checkOutput("retune_period", n, 8);

        // Triangle, full then zero amplitude.
        applyStimulus(1, 1, 64'h1000_0000, 3, 0, 64'hFFFF);
        waitWrap(n);
        step(2);
        for (int i = 0; i < 16; i++) begin
            s[i] = longint'(tone);
            step(1);
        end
        checkOutput("tri_min", s[0], -8388480);
        checkOutput("tri_max", s[8], 8388479);
        bad = 0;
        for (int i = 0; i < 8; i++) if (s[i+1] <= s[i]) bad++;
        for (int i = 8; i < 15; i++) if (s[i+1] >= s[i]) bad++;
        checkOutput("tri_monotonic", bad, 0);

        applyStimulus(1, 1, 64'h1000_0000, 3, 0, 0);
        waitWrap(n);
        step(2);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (tone != 0 || tone_valid != 1'b1) bad++;
            step(1);
        end
        checkOutput("tri_amp0", bad, 0);

        // Enable gating with a write during the stopped window.
        waitPhase(64'h5000_0000);
        applyStimulus(0, 0, 0, 0, 0, 0);
        step(1);
        checkOutput("gate_valid_lag", longint'(tone_valid), 1);
        step(1);
        checkOutput("gate_valid_off", longint'(tone_valid), 0);
        applyStimulus(0, 1, 64'h1000_0000, 1, 64, 64'hFFFF);
        step(1);
        checkOutput("gate_cfg_immediate", longint'(cfg_pending), 0);
        step(2);
        applyStimulus(1, 0, 0, 0, 0, 0);
        step(1);
        checkOutput("resume_valid_lag", longint'(tone_valid), 0);
        step(1);
        checkOutput("resume_valid", longint'(tone_valid), 1);
        checkOutput("resume_tone", longint'(tone), -8388480);

        // Pending A overwritten by B written on the wrap edge.
        waitPhase(64'h8000_0000);
        applyStimulus(1, 1, 64'h2000_0000, 2, 0, 64'h8000);
        step(1);
        checkOutput("a_pending", longint'(cfg_pending), 1);
        waitPhase(64'hF000_0000);
        applyStimulus(1, 1, 64'h4000_0000, 3, 0, 64'hFFFF);
        waitWrap(n);
        checkOutput("b_on_wrap", n, 1);
        checkOutput("b_pending", longint'(cfg_pending), 0);
        waitWrap(n);
        checkOutput("b_period", n, 4);

        // Asynchronous reset between edges while a config is pending.
        waitPhase(64'h4000_0000);
        applyStimulus(1, 1, 64'h1000_0000, 1, 128, 64'hFFFF);
        step(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_tone", longint'(tone), 0);
        checkOutput("arst_valid", longint'(tone_valid), 0);
        checkOutput("arst_wrap", longint'(wrap), 0);
        checkOutput("arst_pending", longint'(cfg_pending), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        checkOutput("post_reset_tone", longint'(tone), 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            longint inc;
            inc = ($urandom_range(0, 31) == 0) ? 0 :
                  (longint'($urandom_range(1, 15)) << 28) | longint'($urandom_range(0, 32'h0FFF_FFFF));
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, inc,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                          longint'($urandom_range(0, 65535)));
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_osc.md
Name: tone_osc

Overview:
- Parametrised phase-accumulator (DDS) tone oscillator. Successor to the fixed-amplitude square generator.
- Adds selectable waveform (square with duty, sawtooth, triangle), runtime amplitude scaling and glitch-free retuning.
- Config changes are shadowed and applied only at a phase wrap.
- Sits between the synth control register file and the audio mixer; output is a signed sample every clock.

Parameters:
- PHASE_W, 32, phase accumulator width; output frequency = f_clk * inc / 2^PHASE_W.
- OUT_W, 24, signed output sample width (OUT_W <= PHASE_W-1).
- AMP_W, 16, unsigned amplitude width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable.
- cfg_wr  in  1  one-cycle strobe; captures cfg_* into the pending shadow.
- cfg_inc  in  PHASE_W  phase increment.
- cfg_mode  in  2  waveform: 0 off, 1 square, 2 saw, 3 triangle.
- cfg_duty  in  8  square high fraction, duty/256.
- cfg_amp  in  AMP_W  amplitude, unsigned.
- cfg_pending  out  1  shadow holds an unapplied config.
- wrap  out  1  one-cycle pulse when the phase accumulator overflows.
- tone  out  OUT_W  signed sample.
- tone_valid  out  1  tone is from a running oscillator (en pipelined).

Behaviour:
- Reset (rst_n low, asynchronous):
  - phase, active config and pending config all 0; cfg_pending = 0.
  - Pipeline registers = 0; tone = 0, tone_valid = 0, wrap = 0.
- Phase:
  - When en = 1: phase <= phase + inc_active, modulo 2^PHASE_W.
  - wrap = 1 in the cycle after the add carries out.
  - When en = 0: phase holds.
- Config shadow:
  - cfg_wr loads the pending registers and sets cfg_pending.
  - A second cfg_wr while pending overwrites the shadow (last write wins).
  - Pending is copied to active, and cfg_pending cleared, on the same edge that sets wrap. It is also applied on any edge where en = 0, i.e. immediately.
  - cfg_wr coincident with the applying edge: the new cfg_* values go straight to active, cfg_pending = 0.
- Shaping, stage 1 (registered). Let FS = 2^(OUT_W-1)-1, and let p = phase[PHASE_W-1 -: OUT_W].
  - Square: w = +FS if phase[PHASE_W-1 -: 8] < duty, else -FS. duty = 0 gives constant -FS; duty = 128 gives 50%.
  - Saw: w = p with its MSB inverted, as signed (ramp from min to max). The value -2^(OUT_W-1) is clamped to -FS.
  - Triangle: u = phase[PHASE_W-2 -: OUT_W], bitwise-inverted when phase[PHASE_W-1] = 1. Then w = u with MSB inverted, as signed, and -2^(OUT_W-1) is clamped to -FS.
  - Off: w = 0.
- Scaling, stage 2 (registered):
  - tone = (w * amp_active) >>> AMP_W.
  - Signed × unsigned product, width OUT_W+AMP_W+1; arithmetic shift (floor); result fits OUT_W with no saturation needed.
- Latency: phase register → tone is 2 clocks. en → tone_valid is 2 clocks.
  - Where tone_valid = 0 the stage-2 output is forced to 0.
- Mode or amplitude changes take effect only via the shadow, so there is no mid-cycle glitch while running.
- inc = 0 with en = 1: phase frozen, wrap never pulses, pending never applied until en drops. This is documented behaviour, not an error.

Decomposition:
- Package tone_pkg holds:
  - the mode encoding constants MODE_OFF / MODE_SQUARE / MODE_SAW / MODE_TRI;
  - the FS helper function.
- One natural sub-module: tone_shaper, the combinational phase-to-w mapping per mode, registered in the parent.
- The shadow/apply logic and multiplier stay in tone_osc.

Test Plan (PHASE_W=32, OUT_W=24, AMP_W=16):
1. Assert rst_n = 0 mid-run, asynchronously between edges → tone, tone_valid, wrap, cfg_pending go 0 immediately. After release with en = 0, tone stays 0.
2. Square wave:
   - Stimulus: cfg_wr inc = 0x1000_0000, mode = 1, duty = 128, amp = 0xFFFF; then en = 1.
   - Required: period 16 clocks; 8 samples of +8388479 then 8 of -8388480; wrap every 16 clocks.
3. Retune:
   - Stimulus: while running, cfg_wr inc = 0x2000_0000 at phase 0x3000_0000.
   - Required: cfg_pending = 1 until the next wrap edge. The old 16-clock period completes, then the period becomes 8. No short or partial cycle.
4. Triangle:
   - Stimulus: inc = 0x1000_0000, mode = 3, amp = 0xFFFF.
   - Required: minimum -8388480 at phase 0, maximum at phase 0x8000_0000, monotonic between.
   - Repeat with amp = 0 → tone constant 0, tone_valid = 1.
5. Enable gating:
   - Stimulus: drop en mid-period for 5 clocks.
   - Required: tone_valid and tone go 0 two clocks later; phase held; a cfg_wr during this time applies at once (cfg_pending never high). Re-raise en → output resumes from the held phase after 2 clocks.
6. cfg_wr coincident with the wrap edge:
   - Stimulus: pending A, then write B on the wrap edge.
   - Required: B becomes active, A is discarded, cfg_pending = 0.
